// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM scanline request path: FSM state
// encoding, channel-index width helper and the default row widths that the
// sampler, generator and SDRAM controller agree on.
package sdram_arb_pkg;

  localparam int DEFAULT_ROW_W       = 10;
  localparam int DEFAULT_CACHE_ROW_W = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_sync.sv
// Single-bit multi-flop synchroniser for a requester's req line, bringing it
// into the SDRAM clock domain. All stages clear on reset.
module req_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sdram_line_arbiter.sv
// Arbitrates NUM_CH scanline transfer requesters onto one SDRAM burst engine.
// Each requester runs a 4-phase req/ack handshake from its own clock domain;
// req is synchronised here, a winner is picked round-robin, its rows are
// captured into a command, and ack is returned once the burst is done.
// Optional build macro SDRAM_ARB_PRIO0_EN: channel 0 gets strict priority
// over the round-robin channels (protects the sampler against overrun).
module sdram_line_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                NUM_CH      = 2,
  parameter int                ROW_W       = DEFAULT_ROW_W,
  parameter int                CACHE_ROW_W = DEFAULT_CACHE_ROW_W,
  parameter logic [NUM_CH-1:0] WRITE_MASK  = NUM_CH'(1),
  parameter int                SYNC_STAGES = 2,
  localparam int               CH_W        = ch_width(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CH-1:0]             ch_req,
  output logic [NUM_CH-1:0]             ch_ack,
  input  logic [NUM_CH*CACHE_ROW_W-1:0] ch_cache_row,
  input  logic [NUM_CH*ROW_W-1:0]       ch_sdram_row,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_write,
  output logic [CH_W-1:0]               cmd_ch,
  output logic [CACHE_ROW_W-1:0]        cmd_cache_row,
  output logic [ROW_W-1:0]              cmd_sdram_row,
  input  logic                          cmd_done,
  output logic                          busy
);

  logic [1:0]        state;
  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] rr_elig;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   win_ch;
  logic              win_found;
  logic              upd_ptr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_sync
    req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (ch_req[c]),
      .q       (req_s[c])
    );
  end

  // A channel may be served only while it requests and holds no ack.
  assign elig = req_s & ~ch_ack;

  // Winner selection: round-robin search from rr_ptr+1, optionally
  // overridden by channel 0 which then leaves the pointer untouched.
  // NOTE: every variable gets a default at the top of the block so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_ch    = '0;
    upd_ptr   = 1'b0;
    rr_elig   = elig;
`ifdef SDRAM_ARB_PRIO0_EN
    rr_elig[0] = 1'b0;
`endif
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!win_found && rr_elig[idx]) begin
        win_found = 1'b1;
        win_ch    = CH_W'(idx);
        upd_ptr   = 1'b1;
      end
    end
`ifdef SDRAM_ARB_PRIO0_EN
    if (elig[0]) begin
      win_found = 1'b1;
      win_ch    = '0;
      upd_ptr   = 1'b0;
    end
`endif
  end

  // Command FSM: capture the winner, hold the command until accepted,
  // then wait for the burst engine to report completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= CH_W'(NUM_CH - 1);
      cmd_valid     <= 1'b0;
      cmd_write     <= 1'b0;
      cmd_ch        <= '0;
      cmd_cache_row <= '0;
      cmd_sdram_row <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            cmd_ch        <= win_ch;
            cmd_write     <= WRITE_MASK[win_ch];
            cmd_cache_row <= ch_cache_row[win_ch*CACHE_ROW_W +: CACHE_ROW_W];
            cmd_sdram_row <= ch_sdram_row[win_ch*ROW_W +: ROW_W];
            cmd_valid     <= 1'b1;
            state         <= ST_ISSUE;
            if (upd_ptr) begin
              rr_ptr <= win_ch;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cmd_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-channel ack: raised when the granted burst completes, dropped on the
  // first cycle the synchronised req is low, independently of the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_ack <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (state == ST_WAIT && cmd_done && cmd_ch == CH_W'(c)) begin
          ch_ack[c] <= 1'b1;
        end else if (!req_s[c]) begin
          ch_ack[c] <= 1'b0;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_line_arbiter.sv
// Directed bench for sdram_line_arbiter: a two-channel instance (default
// parameters) and a four-channel instance with WRITE_MASK=4'b0011.
module tb_sdram_line_arbiter;

  localparam logic [3:0] WMASK_B = 4'b0011;

  logic clk;
  logic reset_n;

  // Two-channel instance
  logic [1:0]  a_req;
  logic [1:0]  a_ack;
  logic [1:0]  a_cache_row;
  logic [19:0] a_sdram_row;
  logic        a_valid;
  logic        a_ready;
  logic        a_write;
  logic [0:0]  a_ch;
  logic [0:0]  a_cmd_cache;
  logic [9:0]  a_cmd_sdram;
  logic        a_done;
  logic        a_busy;

  // Four-channel instance
  logic [3:0]  b_req;
  logic [3:0]  b_ack;
  logic [3:0]  b_cache_row;
  logic [39:0] b_sdram_row;
  logic        b_valid;
  logic        b_ready;
  logic        b_write;
  logic [1:0]  b_ch;
  logic [0:0]  b_cmd_cache;
  logic [9:0]  b_cmd_sdram;
  logic        b_done;
  logic        b_busy;

  int checks;
  int errors;

  sdram_line_arbiter u_dut_a (
    .clk           (clk),
    .reset_n       (reset_n),
    .ch_req        (a_req),
    .ch_ack        (a_ack),
    .ch_cache_row  (a_cache_row),
    .ch_sdram_row  (a_sdram_row),
    .cmd_valid     (a_valid),
    .cmd_ready     (a_ready),
    .cmd_write     (a_write),
    .cmd_ch        (a_ch),
    .cmd_cache_row (a_cmd_cache),
    .cmd_sdram_row (a_cmd_sdram),
    .cmd_done      (a_done),
    .busy          (a_busy)
  );

  sdram_line_arbiter #(
    .NUM_CH     (4),
    .WRITE_MASK (WMASK_B)
  ) u_dut_b (
    .clk           (clk),
    .reset_n       (reset_n),
    .ch_req        (b_req),
    .ch_ack        (b_ack),
    .ch_cache_row  (b_cache_row),
    .ch_sdram_row  (b_sdram_row),
    .cmd_valid     (b_valid),
    .cmd_ready     (b_ready),
    .cmd_write     (b_write),
    .cmd_ch        (b_ch),
    .cmd_cache_row (b_cmd_cache),
    .cmd_sdram_row (b_cmd_sdram),
    .cmd_done      (b_done),
    .busy          (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    a_req       = '0;
    a_ready     = 1'b0;
    a_done      = 1'b0;
    a_cache_row = 2'b10;
    a_sdram_row = {10'h155, 10'h2AA};
    b_req       = '0;
    b_ready     = 1'b0;
    b_done      = 1'b0;
    b_cache_row = 4'b1010;
    b_sdram_row = {10'h103, 10'h102, 10'h101, 10'h100};
    tick(3);
    checks++;
    if ({a_ack, a_valid, a_write, a_ch, a_cmd_cache, a_cmd_sdram, a_busy} !== 17'h0) begin
      errors++;
      $display("FAIL reset_a: got %h expected 0",
               {a_ack, a_valid, a_write, a_ch, a_cmd_cache, a_cmd_sdram, a_busy});
    end
    checks++;
    if ({b_ack, b_valid, b_write, b_ch, b_cmd_cache, b_cmd_sdram, b_busy} !== 20'h0) begin
      errors++;
      $display("FAIL reset_b: got %h expected 0",
               {b_ack, b_valid, b_write, b_ch, b_cmd_cache, b_cmd_sdram, b_busy});
    end
    #3;
    reset_n = 1'b1;
    tick(3);
    checks++;
    if ({a_valid, a_busy, b_valid, b_busy} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000", {a_valid, a_busy, b_valid, b_busy});
    end
  endtask

  task automatic test_single();
    a_req = 2'b10;
    tick(2);
    checks++;
    if (a_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got %b expected 0", a_valid);
    end
    tick(1);
    checks++;
    if ({a_valid, a_ch, a_write, a_cmd_cache, a_cmd_sdram, a_busy} !== {1'b1, 1'b1, 1'b0, 1'b1, 10'h155, 1'b1}) begin
      errors++;
      $display("FAIL single_cmd: got v=%b ch=%h w=%b cache=%h row=%h busy=%b expected v=1 ch=1 w=0 cache=1 row=155 busy=1",
               a_valid, a_ch, a_write, a_cmd_cache, a_cmd_sdram, a_busy);
    end
    a_ready = 1'b1;
    tick(1);
    a_ready = 1'b0;
    checks++;
    if ({a_valid, a_busy, a_ack} !== 4'b0100) begin
      errors++;
      $display("FAIL single_wait: got valid/busy/ack %b expected 0100", {a_valid, a_busy, a_ack});
    end
    a_done = 1'b1;
    tick(1);
    a_done = 1'b0;
    checks++;
    if ({a_ack, a_busy} !== 3'b100) begin
      errors++;
      $display("FAIL single_ack: got ack/busy %b expected 100", {a_ack, a_busy});
    end
    a_req = 2'b00;
    tick(2);
    checks++;
    if (a_ack !== 2'b10) begin
      errors++;
      $display("FAIL single_ack_hold: got %b expected 10", a_ack);
    end
    tick(1);
    checks++;
    if (a_ack !== 2'b00) begin
      errors++;
      $display("FAIL single_ack_clear: got %b expected 00", a_ack);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad    = 0;
    a_done = 1'b1;
    tick(1);
    a_done = 1'b0;
    tick(1);
    checks++;
    if ({a_valid, a_busy, a_ack} !== 4'b0) begin
      errors++;
      $display("FAIL stray_done_idle: got valid/busy/ack %b expected 0000", {a_valid, a_busy, a_ack});
    end
    a_req = 2'b01;
    tick(3);
    checks++;
    if ({a_valid, a_ch, a_write, a_cmd_cache, a_cmd_sdram} !== {1'b1, 1'b0, 1'b1, 1'b0, 10'h2AA}) begin
      errors++;
      $display("FAIL bp_cmd: got v=%b ch=%h w=%b cache=%h row=%h expected v=1 ch=0 w=1 cache=0 row=2aa",
               a_valid, a_ch, a_write, a_cmd_cache, a_cmd_sdram);
    end
    for (int i = 0; i < 20; i++) begin
      a_done = (i == 7);
      tick(1);
      if ({a_valid, a_ch, a_write, a_cmd_cache, a_cmd_sdram, a_busy, a_ack}
          !== {1'b1, 1'b0, 1'b1, 1'b0, 10'h2AA, 1'b1, 2'b00}) begin
        bad++;
      end
    end
    a_done = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad);
    end
    a_ready = 1'b1;
    a_done  = 1'b1;
    tick(1);
    a_ready = 1'b0;
    a_done  = 1'b0;
    tick(3);
    checks++;
    if ({a_valid, a_busy, a_ack} !== 4'b0100) begin
      errors++;
      $display("FAIL done_with_ready: got valid/busy/ack %b expected 0100", {a_valid, a_busy, a_ack});
    end
    a_done = 1'b1;
    tick(1);
    a_done = 1'b0;
    tick(3);
    checks++;
    if ({a_valid, a_busy, a_ack} !== 4'b0001) begin
      errors++;
      $display("FAIL bp_ack_no_regrant: got valid/busy/ack %b expected 0001", {a_valid, a_busy, a_ack});
    end
    a_req = 2'b00;
    tick(3);
    checks++;
    if (a_ack !== 2'b00) begin
      errors++;
      $display("FAIL bp_ack_clear: got %b expected 00", a_ack);
    end
  endtask

  task automatic test_reset_wait();
    logic found;
    found = 1'b0;
    a_req = 2'b10;
    tick(3);
    a_ready = 1'b1;
    tick(1);
    a_ready = 1'b0;
    tick(2);
    checks++;
    if ({a_valid, a_busy} !== 2'b01) begin
      errors++;
      $display("FAIL rst_pre_wait: got valid/busy %b expected 01", {a_valid, a_busy});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_ack, a_valid, a_write, a_ch, a_cmd_cache, a_cmd_sdram, a_busy} !== 17'h0) begin
      errors++;
      $display("FAIL rst_mid_wait: got %h expected 0",
               {a_ack, a_valid, a_write, a_ch, a_cmd_cache, a_cmd_sdram, a_busy});
    end
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (a_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || a_ch !== 1'b1 || a_cmd_sdram !== 10'h155 || a_cmd_cache !== 1'b1) begin
      errors++;
      $display("FAIL rst_regrant: got found=%b ch=%h row=%h cache=%h expected found=1 ch=1 row=155 cache=1",
               found, a_ch, a_cmd_sdram, a_cmd_cache);
    end
    a_ready = 1'b1;
    tick(1);
    a_ready = 1'b0;
    a_done  = 1'b1;
    tick(1);
    a_done  = 1'b0;
    checks++;
    if (a_ack !== 2'b10) begin
      errors++;
      $display("FAIL rst_regrant_ack: got %b expected 10", a_ack);
    end
    a_req = 2'b00;
    tick(4);
  endtask

  // Drives the four-channel instance: each requester in chans drops req when
  // acked and re-raises it as soon as its ack clears; the engine accepts each
  // command at once and reports done wait_cyc cycles later. exp holds the
  // required grant order, first grant in the low two bits.
  task automatic run_grants(input string name, input logic [3:0] chans,
                            input int wait_cyc, input logic [11:0] exp);
    int grants;
    int dones;
    int cnt;
    logic [1:0] e;
    grants = 0;
    dones  = 0;
    cnt    = 0;
    b_req  = chans;
    for (int cyc = 0; cyc < 600 && dones < 6; cyc++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (chans[c]) begin
          if (b_ack[c] && b_req[c]) b_req[c] = 1'b0;
          else if (!b_ack[c] && !b_req[c]) b_req[c] = 1'b1;
        end
      end
      b_done = 1'b0;
      if (b_ready) begin
        b_ready = 1'b0;
        cnt     = wait_cyc;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          b_done = 1'b1;
          dones++;
        end
      end else if (b_valid === 1'b1) begin
        e = exp[grants*2 +: 2];
        checks++;
        if (b_ch !== e || b_write !== WMASK_B[e] || b_cmd_sdram !== (10'h100 + 10'(e))
            || b_cmd_cache !== e[0]) begin
          errors++;
          $display("FAIL %s_grant%0d: got ch=%0d w=%b row=%h cache=%h expected ch=%0d w=%b row=%h cache=%h",
                   name, grants, b_ch, b_write, b_cmd_sdram, b_cmd_cache,
                   e, WMASK_B[e], 10'h100 + 10'(e), e[0]);
        end
        grants++;
        b_ready = 1'b1;
      end
    end
    checks++;
    if (dones < 6) begin
      errors++;
      $display("FAIL %s_timeout: got %0d completed bursts expected 6", name, dones);
    end
    b_req   = '0;
    b_done  = 1'b0;
    b_ready = 1'b0;
    pulse_reset();
    tick(4);
  endtask

  task automatic test_contention();
    run_grants("contention", 4'b1111, 2, {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
  endtask

  task automatic test_prio0();
`ifdef SDRAM_ARB_PRIO0_EN
    run_grants("prio0", 4'b0111, 6, {2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0});
`else
    run_grants("prio0", 4'b0111, 6, {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0});
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_reset_wait();
    test_contention();
    test_prio0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
